imem_server: RTL and testbench

Multi-cycle instruction memory responder for the fetch stage. Accepts a fetch request (byte address) from the instruction-fetch unit and returns the 32-bit instruction word after a fixed number of wait states, with a one-cycle acknowledge. It also exposes a word-write loader port so a test harness or boot loader can program the array. It replaces the zero-latency combinational instruction ROM when the fetch stage runs with a stall/handshake.

---
 rtl/imem_server.sv | 158 +++++++++++++++
 tb/tb_imem_server.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_server.sv
// imem_server: multi-cycle instruction memory responder for the fetch stage.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, and answers
// with a one-cycle Ack in RESP. A side loader port programs the word array.
module imem_server #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic                  Clk,
    input  logic                  Clrn,
    input  logic                  Req,
    input  logic [31:0]           Addr,
    output logic                  Ack,
    output logic [31:0]           Inst,
    output logic                  Err,
    output logic                  Busy,
    input  logic                  WrEn,
    input  logic [DEPTH_LOG2-1:0] WrAddr,
    input  logic [31:0]           WrData
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Wait counter preload; unused (and forced to zero) for the zero-latency build.
    localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic [31:0] addr_q_r;
    logic        ack_r;
    logic        busy_r;
    logic        err_r;
    logic [31:0] inst_r;

    logic        accept_s;
    logic        capture_s;
    logic [31:0] cap_addr_s;
    logic        cap_err_s;
    logic [31:0] cap_word_s;

    // Storage is zero at power-up and deliberately not touched by Clrn.
    logic [31:0] mem_r [DEPTH] = '{default: 32'h0000_0000};

    // Fetch fault: misaligned byte address or any address bit above the array.
    function automatic logic fetch_fault(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (DEPTH_LOG2 + 2);
        return (a[1:0] != 2'b00) || (hi != 32'h0000_0000);
    endfunction

    // Next-state, counter and capture-strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Req) begin
                    accept_s = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt_s = ST_RESP;
                        cnt_nxt_s   = 4'd0;
                        capture_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = CNT_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Capture address: with zero latency the capture edge is also the accepting
    // edge, so the live Addr is used instead of the not-yet-latched copy.
    always_comb begin
        cap_addr_s = addr_q_r;
        if (state_r == ST_IDLE) begin
            cap_addr_s = Addr;
        end else begin
            cap_addr_s = addr_q_r;
        end
    end

    // Response data: NOP with error flag on a fault, else the addressed word.
    always_comb begin
        cap_err_s  = fetch_fault(cap_addr_s);
        cap_word_s = 32'h0000_0000;
        if (cap_err_s) begin
            cap_word_s = 32'h0000_0000;
        end else begin
            cap_word_s = mem_r[cap_addr_s[DEPTH_LOG2+1:2]];
        end
    end

    // State, counter, latched address and registered response outputs.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            addr_q_r <= 32'h0000_0000;
            ack_r    <= 1'b0;
            busy_r   <= 1'b0;
            inst_r   <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ack_r   <= (state_nxt_s == ST_RESP);
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (accept_s) begin
                addr_q_r <= Addr;
            end
            if (capture_s) begin
                inst_r <= cap_word_s;
                err_r  <= cap_err_s;
            end
        end
    end

    // Loader write port; a read on the same edge sees the old word.
    always_ff @(posedge Clk) begin
        if (WrEn && Clrn) begin
            mem_r[WrAddr] <= WrData;
        end
    end

    assign Ack  = ack_r;
    assign Busy = busy_r;
    assign Inst = inst_r;
    assign Err  = err_r;

endmodule

// File: tb/tb_imem_server.sv
// Testbench for imem_server: directed table, hand-written corner sequences,
// and randomized fetch/load traffic checked against a word-array model.
module tb_imem_server;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic        Req = 1'b0;
    logic [31:0] Addr = 32'h0;
    logic        Ack;
    logic [31:0] Inst;
    logic        Err;
    logic        Busy;
    logic        WrEn = 1'b0;
    logic [5:0]  WrAddr = 6'd0;
    logic [31:0] WrData = 32'h0;

    logic        z_req = 1'b0;
    logic [31:0] z_addr = 32'h0;
    logic        z_ack;
    logic [31:0] z_inst;
    logic        z_err;
    logic        z_busy;
    logic        z_wren = 1'b0;
    logic [5:0]  z_wraddr = 6'd0;
    logic [31:0] z_wrdata = 32'h0;

    imem_server #(.DEPTH_LOG2(6), .LATENCY(2)) dut (
        .Clk(Clk), .Clrn(Clrn), .Req(Req), .Addr(Addr), .Ack(Ack), .Inst(Inst),
        .Err(Err), .Busy(Busy), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData)
    );

    imem_server #(.DEPTH_LOG2(6), .LATENCY(0)) dut_z (
        .Clk(Clk), .Clrn(Clrn), .Req(z_req), .Addr(z_addr), .Ack(z_ack), .Inst(z_inst),
        .Err(z_err), .Busy(z_busy), .WrEn(z_wren), .WrAddr(z_wraddr), .WrData(z_wrdata)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [64];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] a);
        if (model_err(a)) return 32'h0;
        return ref_mem[a / 32'd4];
    endfunction

    task automatic load(input int idx, input logic [31:0] d);
        WrEn = 1'b1;
        WrAddr = 6'(idx);
        WrData = d;
        tick();
        WrEn = 1'b0;
        ref_mem[idx] = d;
    endtask

    // One complete fetch with latency, busy-width, data and pulse-width checks.
    task automatic fetch_exp(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                             input string name);
        int cyc;
        int busy_cnt;
        bit got;
        Req = 1'b1;
        Addr = a;
        cyc = 0;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (Busy) busy_cnt++;
            if (Ack) got = 1'b1;
            if (cyc == 1) Addr = $urandom;
        end
        Req = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no Ack, expected Ack within 20 cycles", name);
        end else begin
            chk({name, "_latency"}, cyc, 32'd3);
            chk({name, "_inst"}, Inst, ei);
            chk({name, "_err"}, {31'b0, Err}, {31'b0, ee});
            chk({name, "_busy_cycles"}, busy_cnt, 32'd3);
        end
        tick();
        chk({name, "_ack_single"}, {31'b0, Ack}, 32'd0);
        chk({name, "_busy_low"}, {31'b0, Busy}, 32'd0);
        chk({name, "_inst_hold"}, Inst, ei);
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_exp(a, model_inst(a), model_err(a), "rand_fetch");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks [$];
        logic [31:0] ainst [$];
        int cnt;

        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        // Reset state.
        tick();
        tick();
        chk("rst_ack", {31'b0, Ack}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_inst", Inst, 32'd0);
        chk("rst_err", {31'b0, Err}, 32'd0);
        Clrn = 1'b1;
        tick();

        // Directed table.
        load(3, 32'h2002_0005);
        load(0, 32'h0000_0013);
        load(1, 32'h00A0_0093);
        load(63, 32'hCAFE_F00D);
        vecs[0] = '{32'h0000_000C, 32'h2002_0005, 1'b0};
        vecs[1] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h0000_0100, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
        vecs[4] = '{32'h0000_0004, 32'h00A0_0093, 1'b0};
        vecs[5] = '{32'h0000_00FC, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{32'h0000_00FE, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'h0000_0008, 32'h0000_0000, 1'b0};
        for (int i = 0; i < 9; i++) begin
            fetch_exp(vecs[i].addr, vecs[i].inst, vecs[i].err, $sformatf("vec%0d", i));
        end

        // Read/write collision on the capture edge.
        load(5, 32'h1234_5678);
        Req = 1'b1;
        Addr = 32'h0000_0014;
        tick();
        tick();
        WrEn = 1'b1;
        WrAddr = 6'd5;
        WrData = 32'hFFFF_FFFF;
        tick();
        WrEn = 1'b0;
        Req = 1'b0;
        chk("coll_ack", {31'b0, Ack}, 32'd1);
        chk("coll_old_word", Inst, 32'h1234_5678);
        ref_mem[5] = 32'hFFFF_FFFF;
        tick();
        fetch_exp(32'h0000_0014, 32'hFFFF_FFFF, 1'b0, "coll_refetch");

        // Write during WAIT is visible in the same fetch.
        load(7, 32'h1111_1111);
        Req = 1'b1;
        Addr = 32'h0000_001C;
        tick();
        WrEn = 1'b1;
        WrAddr = 6'd7;
        WrData = 32'h2222_2222;
        tick();
        WrEn = 1'b0;
        tick();
        Req = 1'b0;
        chk("wwait_ack", {31'b0, Ack}, 32'd1);
        chk("wwait_inst", Inst, 32'h2222_2222);
        ref_mem[7] = 32'h2222_2222;
        tick();

        // Back-to-back with Req held high.
        Req = 1'b1;
        Addr = 32'h0000_0000;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (Ack) begin
                acks.push_back(c);
                ainst.push_back(Inst);
                if (acks.size() == 1) Addr = 32'h0000_0004;
                if (acks.size() == 2) begin
                    Req = 1'b0;
                    break;
                end
            end
        end
        Req = 1'b0;
        if (acks.size() != 2) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_acks: got %0d Ack pulses, expected 2", acks.size());
        end else begin
            chk("b2b_first_lat", acks[0], 32'd3);
            chk("b2b_spacing", acks[1] - acks[0], 32'd4);
            chk("b2b_inst0", ainst[0], 32'h0000_0013);
            chk("b2b_inst1", ainst[1], 32'h00A0_0093);
        end
        tick();
        chk("b2b_ack_end", {31'b0, Ack}, 32'd0);

        // Zero-latency instance; also leaves a nonzero Inst for the reset check.
        z_wren = 1'b1;
        z_wraddr = 6'd2;
        z_wrdata = 32'hABCD_0001;
        tick();
        z_wren = 1'b0;
        z_req = 1'b1;
        z_addr = 32'h0000_0008;
        tick();
        chk("lat0_ack", {31'b0, z_ack}, 32'd1);
        chk("lat0_inst", z_inst, 32'hABCD_0001);
        chk("lat0_err", {31'b0, z_err}, 32'd0);
        chk("lat0_busy", {31'b0, z_busy}, 32'd1);
        z_addr = 32'h0000_000C;
        z_req = 1'b0;
        tick();
        chk("lat0_ack_end", {31'b0, z_ack}, 32'd0);
        chk("lat0_inst_hold", z_inst, 32'hABCD_0001);
        chk("lat0_busy_end", {31'b0, z_busy}, 32'd0);

        // Reset mid-WAIT: outputs clear at once, request dropped, loader ignored.
        fetch_exp(32'h0000_0006, 32'h0, 1'b1, "pre_rst_err");
        Req = 1'b1;
        Addr = 32'h0000_000C;
        tick();
        tick();
        Clrn = 1'b0;
        #1;
        chk("mid_rst_ack", {31'b0, Ack}, 32'd0);
        chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
        chk("mid_rst_inst", Inst, 32'd0);
        chk("mid_rst_err", {31'b0, Err}, 32'd0);
        chk("mid_rst_z_inst", z_inst, 32'd0);
        Req = 1'b0;
        WrEn = 1'b1;
        WrAddr = 6'd9;
        WrData = 32'hDEAD_BEEF;
        tick();
        tick();
        WrEn = 1'b0;
        Clrn = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (Ack) cnt++;
        end
        chk("post_rst_no_ack", cnt, 32'd0);
        fetch_exp(32'h0000_0024, 32'h0000_0000, 1'b0, "rst_write_ignored");

        // Randomized traffic against the word-array model.
        for (int i = 0; i < 40; i++) begin
            int op;
            int idx;
            op = $urandom_range(0, 2);
            idx = $urandom_range(0, 63);
            if (op == 0) begin
                load(idx, $urandom);
            end else if ($urandom_range(0, 3) != 0) begin
                fetch(32'(idx) * 32'd4);
            end else begin
                fetch($urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
